// File: rtl/snake_pkg.sv
// Shared definitions for the snake engine: game states, direction codes,
// direction helpers and width helpers used to size grid/length buses.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_RUNNING = 2'd0,
    ST_DIE     = 2'd1,
    ST_INITIAL = 2'd2,
    ST_PAUSED  = 2'd3
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_of(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  // Codes are paired so that flipping bit 0 gives the reverse direction.
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

  function automatic int dir_dx(input logic [1:0] d);
    case (d)
      DIR_RIGHT: return 1;
      DIR_LEFT:  return -1;
      default:   return 0;
    endcase
  endfunction

  // y grows downwards, so UP decrements.
  function automatic int dir_dy(input logic [1:0] d);
    case (d)
      DIR_UP:   return -1;
      DIR_DOWN: return 1;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/snake_if.sv
// Bus between the snake engine and its neighbours (direction/button logic,
// food, score, display).
//   master: drives dir_valid/dir_in, start, pause, slow, food_x/food_y;
//           observes state, body, length and event pulses.
//   slave : the engine side (reverse directions).
interface snake_if #(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int MAX_LEN = 64
);
  import snake_pkg::*;

  localparam int XW = width_of(GRID_W);
  localparam int YW = width_of(GRID_H);
  localparam int LW = width_of(MAX_LEN + 1);

  logic                  dir_valid;
  logic [1:0]            dir_in;
  logic                  start;
  logic                  pause;
  logic                  slow;
  logic [XW-1:0]         food_x;
  logic [YW-1:0]         food_y;
  logic [1:0]            game_state;
  logic [1:0]            cur_dir;
  logic [MAX_LEN*XW-1:0] snake_x_flat;
  logic [MAX_LEN*YW-1:0] snake_y_flat;
  logic [LW-1:0]         snake_length;
  logic                  step;
  logic                  get_food;
  logic                  hit_boundary;
  logic                  hit_self;

  modport master (
    output dir_valid, dir_in, start, pause, slow, food_x, food_y,
    input  game_state, cur_dir, snake_x_flat, snake_y_flat, snake_length,
           step, get_food, hit_boundary, hit_self
  );

  modport slave (
    input  dir_valid, dir_in, start, pause, slow, food_x, food_y,
    output game_state, cur_dir, snake_x_flat, snake_y_flat, snake_length,
           step, get_food, hit_boundary, hit_self
  );

endinterface

// File: rtl/snake_tick_gen.sv
// Move-rate timer for the snake engine.
//   clk, rst : clock, async active-high reset
//   clear    : force the count to 0
//   en       : count enable (hold when low)
//   slow     : select the stretched period TICK_CYCLES*SLOW_FACTOR
//   tick     : high in the cycle whose closing edge executes a move
module snake_tick_gen #(
  parameter int TICK_CYCLES = 5_000_000,
  parameter int SLOW_FACTOR = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic slow,
  output logic tick
);
  import snake_pkg::*;

  localparam int CW = width_of(TICK_CYCLES * SLOW_FACTOR);
  localparam logic [CW-1:0] TC_FAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] TC_SLOW = CW'(TICK_CYCLES * SLOW_FACTOR - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] tc_val;

  assign tc_val = slow ? TC_SLOW : TC_FAST;

  // >= so that dropping slow while already past the fast terminal count
  // wraps straight away instead of running through the counter range.
  assign tick = en && (cnt >= tc_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake movement/collision engine and game FSM.
//   clk, rst : clock, async active-high reset
//   bus      : snake_if slave -- direction strobe, start/pause/slow levels,
//              food position in; state, current direction, flattened body,
//              length, step/get_food pulses and sticky hit flags out.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_INITIAL | body at start position, waiting for start or a direction
// ST_RUNNING | timer counting, one move per terminal count
// ST_PAUSED  | timer and body held until pause drops
// ST_DIE     | body frozen, hit_* flag shows the cause; start restarts
module snake_engine #(
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int MAX_LEN     = 64,
  parameter int INIT_LEN    = 3,
  parameter int TICK_CYCLES = 5_000_000,
  parameter int SLOW_FACTOR = 2,
  parameter int WRAP        = 0
) (
  input  logic    clk,
  input  logic    rst,
  snake_if.slave  bus
);
  import snake_pkg::*;

  localparam int XW = width_of(GRID_W);
  localparam int YW = width_of(GRID_H);
  localparam int LW = width_of(MAX_LEN + 1);

  state_t        state;
  logic [1:0]    cur_dir;
  logic [1:0]    pending;
  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] length;
  logic          step_q;
  logic          food_q;
  logic          hit_boundary_q;
  logic          hit_self_q;
  logic          tick;

  int            nx;
  int            ny;
  logic [XW-1:0] nh_x;
  logic [YW-1:0] nh_y;
  logic          wall;
  logic          eat;
  logic          grow;
  logic          self_hit;
  logic [LW-1:0] chk_len;
  logic [1:0]    ref_dir;
  logic          dir_take;

  function automatic logic [XW-1:0] init_x(input int i);
    return (i < INIT_LEN) ? XW'(INIT_LEN - 1 - i) : '0;
  endfunction

  function automatic logic [YW-1:0] init_y(input int i);
    return (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
  endfunction

  snake_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES),
    .SLOW_FACTOR (SLOW_FACTOR)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ST_INITIAL),
    .en    (state == ST_RUNNING),
    .slow  (bus.slow),
    .tick  (tick)
  );

  // On a move edge cur_dir is about to become pending, so a request arriving
  // in that same cycle is judged against the direction actually taken.
  assign ref_dir  = tick ? pending : cur_dir;
  assign dir_take = bus.dir_valid && (bus.dir_in != dir_opposite(ref_dir));

  always_comb begin
    nx   = int'(seg_x[0]) + dir_dx(pending);
    ny   = int'(seg_y[0]) + dir_dy(pending);
    wall = 1'b0;
    nh_x = XW'(nx);
    nh_y = YW'(ny);
    if (WRAP != 0) begin
      if (nx < 0)            nh_x = XW'(GRID_W - 1);
      else if (nx >= GRID_W) nh_x = '0;
      if (ny < 0)            nh_y = YW'(GRID_H - 1);
      else if (ny >= GRID_H) nh_y = '0;
    end else begin
      wall = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
    end
    eat  = (nh_x == bus.food_x) && (nh_y == bus.food_y);
    grow = eat && (length < LW'(MAX_LEN));
    // The tail vacates its cell on a normal move, but stays put when growing.
    chk_len  = grow ? length : length - LW'(1);
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < chk_len) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
        self_hit = 1'b1;
    end
    if (wall) self_hit = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_INITIAL;
      cur_dir        <= DIR_RIGHT;
      pending        <= DIR_RIGHT;
      length         <= LW'(INIT_LEN);
      step_q         <= 1'b0;
      food_q         <= 1'b0;
      hit_boundary_q <= 1'b0;
      hit_self_q     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= init_y(i);
      end
    end else begin
      step_q <= 1'b0;
      food_q <= 1'b0;
      if (dir_take) pending <= bus.dir_in;

      case (state)
        ST_INITIAL: begin
          if (bus.start || bus.dir_valid) state <= ST_RUNNING;
        end
        ST_RUNNING: begin
          if (tick && wall) begin
            hit_boundary_q <= 1'b1;
            state          <= ST_DIE;
          end else if (tick && self_hit) begin
            hit_self_q <= 1'b1;
            state      <= ST_DIE;
          end else begin
            if (tick) begin
              cur_dir  <= pending;
              seg_x[0] <= nh_x;
              seg_y[0] <= nh_y;
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              if (grow) length <= length + LW'(1);
              step_q <= 1'b1;
              food_q <= eat;
            end
            if (bus.pause) state <= ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!bus.pause) state <= ST_RUNNING;
        end
        ST_DIE: begin
          if (bus.start) begin
            state          <= ST_INITIAL;
            cur_dir        <= DIR_RIGHT;
            pending        <= DIR_RIGHT;
            length         <= LW'(INIT_LEN);
            hit_boundary_q <= 1'b0;
            hit_self_q     <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
              seg_x[i] <= init_x(i);
              seg_y[i] <= init_y(i);
            end
          end
        end
        default: state <= ST_INITIAL;
      endcase
    end
  end

  assign bus.game_state   = state;
  assign bus.cur_dir      = cur_dir;
  assign bus.snake_length = length;
  assign bus.step         = step_q;
  assign bus.get_food     = food_q;
  assign bus.hit_boundary = hit_boundary_q;
  assign bus.hit_self     = hit_self_q;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
    assign bus.snake_x_flat[g*XW +: XW] = seg_x[g];
    assign bus.snake_y_flat[g*YW +: YW] = seg_y[g];
  end

endmodule
